spike_rate_decoder: RTL and testbench

Output-side rate decoder for the spiking network. It counts spikes on each output neuron line over a fixed observation window and picks the most active channel (winner-take-all). The result is presented on a valid/ready handshake. It is the consumer end of the spike-train path: the stimulus side serialises patterns into spikes, and this block turns the network's output spikes back into a class decision and per-channel counts.

---
 rtl/spike_rate_decoder.sv | 149 ++++++++++++++
 tb/tb_spike_rate_decoder.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/spike_rate_decoder.sv
// -----------------------------------------------------------------------------
// spike_rate_decoder
//
// Counts spikes on each output-neuron line over a fixed window of WINDOW
// clock cycles, then presents the per-channel counts and a winner-take-all
// decision (highest count, lowest index on ties) on a valid/ready port.
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   start        one-cycle request to open a window; honoured only in IDLE
//   spike_in     N_CH spike lines, bit k = neuron k, sampled every edge
//   busy         high while COUNT or HOLD
//   out_valid    result available (HOLD)
//   out_ready    consumer accepts result
//   out_counts   per-channel counts, channel k at [k*CNT_W +: CNT_W]
//   out_winner   index of the channel with the highest count
//   out_tie      maximum count shared by at least two channels
//   dbg_state_o  current FSM state (0 IDLE, 1 COUNT, 2 HOLD)
//
// Handshake: the result transfers on any rising edge where out_valid and
// out_ready are both high; out_valid, once raised, stays high and the result
// stays stable until that edge, and out_valid never depends on out_ready.
// -----------------------------------------------------------------------------
module spike_rate_decoder #(
  parameter int N_CH   = 2,
  parameter int WINDOW = 40,
  parameter int CNT_W  = 6,
  parameter int IDX_W  = $clog2(N_CH)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [N_CH-1:0]         spike_in,
  output logic                    busy,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [N_CH*CNT_W-1:0]   out_counts,
  output logic [IDX_W-1:0]        out_winner,
  output logic                    out_tie,
  output logic [1:0]              dbg_state_o
);

  localparam int WIN_W = $clog2(WINDOW + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_COUNT = 2'd1,
    S_HOLD  = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [WIN_W-1:0]        win_q, win_d;
  logic [CNT_W-1:0]        cnt_q [N_CH];
  logic [CNT_W-1:0]        cnt_d [N_CH];
  logic [N_CH*CNT_W-1:0]   out_counts_q, out_counts_d;
  logic [IDX_W-1:0]        out_winner_q, out_winner_d;
  logic                    out_tie_q, out_tie_d;

  // Saturating increment of every channel, and the winner of those values.
  // The result captured on the last window edge includes that edge's spikes.
  logic [CNT_W-1:0]        cnt_inc [N_CH];
  logic [CNT_W-1:0]        max_c;
  logic [IDX_W-1:0]        max_idx;
  logic                    max_tie;

  always_comb begin
    for (int k = 0; k < N_CH; k++) begin
      cnt_inc[k] = (cnt_q[k] == CNT_MAX) ? cnt_q[k]
                                         : cnt_q[k] + CNT_W'(spike_in[k]);
    end
    max_c   = cnt_inc[0];
    max_idx = '0;
    max_tie = 1'b0;
    // Strict '>' keeps the lowest index on equal counts; a new strict
    // maximum clears any tie seen against the previous maximum.
    for (int k = 1; k < N_CH; k++) begin
      if (cnt_inc[k] > max_c) begin
        max_c   = cnt_inc[k];
        max_idx = IDX_W'(k);
        max_tie = 1'b0;
      end else if (cnt_inc[k] == max_c) begin
        max_tie = 1'b1;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    win_d        = win_q;
    cnt_d        = cnt_q;
    out_counts_d = out_counts_q;
    out_winner_d = out_winner_q;
    out_tie_d    = out_tie_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_COUNT;
          win_d   = '0;
          for (int k = 0; k < N_CH; k++) cnt_d[k] = '0;
        end
      end
      S_COUNT: begin
        cnt_d = cnt_inc;
        win_d = win_q + WIN_W'(1);
        if (win_q == WIN_LAST) begin
          state_d = S_HOLD;
          for (int k = 0; k < N_CH; k++) out_counts_d[k*CNT_W +: CNT_W] = cnt_inc[k];
          out_winner_d = max_idx;
          out_tie_d    = max_tie;
        end
      end
      S_HOLD: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      win_q        <= '0;
      for (int k = 0; k < N_CH; k++) cnt_q[k] <= '0;
      out_counts_q <= '0;
      out_winner_q <= '0;
      out_tie_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      win_q        <= win_d;
      cnt_q        <= cnt_d;
      out_counts_q <= out_counts_d;
      out_winner_q <= out_winner_d;
      out_tie_q    <= out_tie_d;
    end
  end

  // Status flags are pure decodes of the state register, so no input has a
  // combinational path to any output.
  assign busy        = (state_q != S_IDLE);
  assign out_valid   = (state_q == S_HOLD);
  assign out_counts  = out_counts_q;
  assign out_winner  = out_winner_q;
  assign out_tie     = out_tie_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_spike_rate_decoder.sv
// -----------------------------------------------------------------------------
// tb_spike_rate_decoder
//
// Directed bench for spike_rate_decoder. A default instance (CNT_W=6) covers
// counting, ties, window edges, backpressure, ignored starts and reset; a
// second instance with CNT_W=5 covers counter saturation.
// -----------------------------------------------------------------------------
module tb_spike_rate_decoder;

  localparam int WINDOW = 40;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // default instance
  logic        start = 1'b0;
  logic [1:0]  spike_in = '0;
  logic        out_ready = 1'b0;
  logic        busy, out_valid, out_tie;
  logic [11:0] out_counts;
  logic [0:0]  out_winner;
  logic [1:0]  dbg_state;

  // saturation instance (CNT_W = 5)
  logic        start_s = 1'b0;
  logic [1:0]  spike_s = '0;
  logic        ready_s = 1'b0;
  logic        busy_s, valid_s, tie_s;
  logic [9:0]  counts_s;
  logic [0:0]  winner_s;
  logic [1:0]  state_s;

  spike_rate_decoder #(.N_CH(2), .WINDOW(WINDOW), .CNT_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .spike_in(spike_in),
    .busy(busy), .out_valid(out_valid), .out_ready(out_ready),
    .out_counts(out_counts), .out_winner(out_winner), .out_tie(out_tie),
    .dbg_state_o(dbg_state)
  );

  spike_rate_decoder #(.N_CH(2), .WINDOW(WINDOW), .CNT_W(5)) dut_sat (
    .clk(clk), .rst_n(rst_n), .start(start_s), .spike_in(spike_s),
    .busy(busy_s), .out_valid(valid_s), .out_ready(ready_s),
    .out_counts(counts_s), .out_winner(winner_s), .out_tie(tie_s),
    .dbg_state_o(state_s)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_result(input string tag, input logic [11:0] cnts,
                            input logic win, input logic tie);
    chk({tag, "_valid"},  32'(out_valid),  32'd1);
    chk({tag, "_counts"}, 32'(out_counts), 32'(cnts));
    chk({tag, "_winner"}, 32'(out_winner), 32'(win));
    chk({tag, "_tie"},    32'(out_tie),    32'(tie));
  endtask

  // ---------------- drivers ----------------
  // Advance one edge; outputs are sampled 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Spike pattern for window edge t+i (i=0 is the start edge).
  function automatic logic [1:0] spk(input int mode, input int i);
    case (mode)
      0:       spk = {(i % 4 == 0), (i % 2 == 1)};                // ch0 20, ch1 10
      1:       spk = (i >= 1 && i <= 7) ? 2'b11 : 2'b00;          // 7 / 7
      2:       spk = (i == 0) ? 2'b11 : 2'b00;                    // start edge only
      3:       spk = (i == 1 || i == WINDOW) ? 2'b01 : 2'b00;     // first/last edge
      default: spk = 2'b00;
    endcase
  endfunction

  // Start edge plus WINDOW counting edges; optional start pulse at edge t+inj.
  task automatic run_window(input string tag, input int mode, input int inj);
    start    = 1'b1;
    spike_in = spk(mode, 0);
    tick();
    chk({tag, "_busy_t"},  32'(busy),      32'd1);
    chk({tag, "_state_t"}, 32'(dbg_state), 32'd1);
    start = 1'b0;
    for (int i = 1; i <= WINDOW; i++) begin
      spike_in = spk(mode, i);
      start    = (i == inj);
      tick();
      chk({tag, "_valid_win"}, 32'(out_valid), 32'(i == WINDOW));
      chk({tag, "_busy_win"},  32'(busy),      32'd1);
    end
    start    = 1'b0;
    spike_in = '0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [11:0] held_counts;

    // reset state
    #2;
    chk("rst_busy",   32'(busy),       32'd0);
    chk("rst_valid",  32'(out_valid),  32'd0);
    chk("rst_counts", 32'(out_counts), 32'd0);
    chk("rst_winner", 32'(out_winner), 32'd0);
    chk("rst_tie",    32'(out_tie),    32'd0);
    chk("rst_state",  32'(dbg_state),  32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // basic count, out_ready already high
    out_ready = 1'b1;
    run_window("basic", 0, -1);
    chk_result("basic", {6'd10, 6'd20}, 1'b0, 1'b0);
    tick();
    chk("basic_idle_valid", 32'(out_valid),  32'd0);
    chk("basic_idle_busy",  32'(busy),       32'd0);
    chk("basic_keep",       32'(out_counts), 32'({6'd10, 6'd20}));

    // tie, then backpressure with spikes and start pulses in HOLD
    out_ready = 1'b0;
    run_window("tie7", 1, -1);
    chk_result("tie7", {6'd7, 6'd7}, 1'b0, 1'b1);
    for (int c = 0; c < 10; c++) begin
      spike_in = 2'($urandom_range(0, 3));
      start    = c[0];
      tick();
      chk("bp_valid",  32'(out_valid),  32'd1);
      chk("bp_state",  32'(dbg_state),  32'd2);
      chk("bp_counts", 32'(out_counts), 32'({6'd7, 6'd7}));
      chk("bp_tie",    32'(out_tie),    32'd1);
    end
    // handshake edge with start high: start must not be honoured or queued
    out_ready = 1'b1;
    start     = 1'b1;
    tick();
    chk("hs_valid", 32'(out_valid), 32'd0);
    chk("hs_busy",  32'(busy),      32'd0);
    start    = 1'b0;
    spike_in = '0;
    tick();
    chk("hs_noqueue", 32'(busy), 32'd0);

    // spikes only on the start edge and on edge t+41 (the handshake edge)
    run_window("edge0", 2, -1);
    chk_result("edge0", {6'd0, 6'd0}, 1'b0, 1'b1);
    spike_in = 2'b11;
    tick();
    chk("edge0_done",   32'(out_valid),  32'd0);
    chk("edge0_counts", 32'(out_counts), 32'd0);
    spike_in = '0;
    tick();

    // spikes on first and last counted edges, with a start pulse mid-window
    run_window("edge2", 3, 20);
    chk_result("edge2", {6'd0, 6'd2}, 1'b0, 1'b0);
    tick();
    chk("edge2_idle", 32'(busy), 32'd0);

    // saturation on the CNT_W=5 instance: ch1 high all window
    ready_s = 1'b1;
    start_s = 1'b1;
    tick();
    start_s = 1'b0;
    spike_s = 2'b10;
    for (int i = 1; i <= WINDOW; i++) tick();
    spike_s = '0;
    chk("sat_valid",  32'(valid_s),  32'd1);
    chk("sat_counts", 32'(counts_s), 32'({5'd31, 5'd0}));
    chk("sat_winner", 32'(winner_s), 32'd1);
    chk("sat_tie",    32'(tie_s),    32'd0);
    tick();
    chk("sat_idle", 32'(valid_s), 32'd0);

    // asynchronous reset in the middle of a window
    held_counts = out_counts;
    chk("pre_rst_counts", 32'(held_counts), 32'({6'd0, 6'd2}));
    start    = 1'b1;
    spike_in = 2'b11;
    tick();
    start = 1'b0;
    for (int i = 1; i < 20; i++) tick();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy",   32'(busy),       32'd0);
    chk("arst_valid",  32'(out_valid),  32'd0);
    chk("arst_counts", 32'(out_counts), 32'd0);
    chk("arst_state",  32'(dbg_state),  32'd0);
    spike_in = '0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 30; i++) begin
      tick();
      chk("post_rst_valid", 32'(out_valid), 32'd0);
    end

    // fresh independent window after reset
    run_window("fresh", 0, -1);
    chk_result("fresh", {6'd10, 6'd20}, 1'b0, 1'b0);
    tick();
    chk("fresh_idle", 32'(busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
